spi_master_arb: RTL and testbench
=================================

SPI_MASTER_ARB -- requirements
Module: spi_master_arb

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 2..255).
REQ-002 SHALL have parameter DATA_W, default 8, meaning bits per transfer.
REQ-003 SHALL have port clk  in  1  single system clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_i  in  2  transfer request, one bit per requester, held until the matching done_o.
REQ-006 SHALL have ports wdata0_i and wdata1_i  in  DATA_W  transmit byte for requester 0 and requester 1.
REQ-007 SHALL have port gnt_o  out  2  one-hot grant, high from grant through done.
REQ-008 SHALL have port done_o  out  2  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port rdata_o  out  DATA_W  received byte, valid from the done_o pulse until the next done_o.
REQ-010 SHALL have port busy_o  out  1  high in every state except IDLE.
REQ-011 SHALL have ports SCLK, MOSI and CS  out  1  each; SPI mode 0, CS active-low.
REQ-012 SHALL have port MISO  in  1  serial input from the slave.
REQ-013 SHALL have ports data_mosi and data_miso  out  DATA_W  each; the latched transmit byte and the shift-in register, exported for GAO probing.

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-015 Half-period tick SHALL assert every CLK_DIV clk cycles while the FSM is outside IDLE, and its counter SHALL restart on entry to SETUP.
REQ-016 IDLE: when any req_i bit is high, SHALL set gnt_o, latch the winner's wdata into data_mosi, drive CS=0 and MOSI=MSB on the same edge, and go to SETUP.
REQ-017 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset, requester 0 has priority.
REQ-018 SETUP SHALL last one half-period with SCLK=0, then go to SHIFT.
REQ-019 SHIFT SHALL toggle SCLK each tick for 2*DATA_W half-periods.
REQ-020 On each SCLK rising edge, MISO SHALL be sampled into the LSB of data_miso, shifting left.
REQ-021 On each SCLK falling edge except the last, MOSI SHALL advance to the next lower bit.
REQ-022 HOLD SHALL last one half-period with SCLK=0 and CS=0.
REQ-023 At the end of HOLD, on one edge: CS=1, done_o pulses for the granted requester, rdata_o<=data_miso, gnt_o clears, and the FSM goes to GAP.
REQ-024 GAP SHALL last one half-period with CS=1, then return to IDLE; no new grant is issued before IDLE.
REQ-025 CS-low duration SHALL be exactly (2*DATA_W+2)*CLK_DIV cycles (72 at the defaults).
REQ-026 Request-to-CS-low latency SHALL be one edge; back-to-back CS-low windows SHALL be separated by at least CLK_DIV+1 cycles.
REQ-027 A req_i deassertion during a transfer SHALL be ignored; the transfer completes and done_o still pulses.
REQ-028 wdata changes after grant SHALL NOT affect the transfer in progress.
REQ-029 A requester whose req_i is still high after done_o SHALL be re-granted only through normal round-robin.

Reset
REQ-030 On rst_n=0, asynchronously: FSM=IDLE, CS=1, SCLK=0, MOSI=0, gnt_o=0, done_o=0, busy_o=0, rdata_o=0, data_mosi=0, data_miso=0, the round-robin pointer favours requester 0, and the tick counter=0.
REQ-031 Reset asserted mid-transfer SHALL abort it with no done_o pulse; CS SHALL rise in the same cycle.

Structure
REQ-032 Shared package spi_pkg SHALL hold the FSM state type, the CLK_DIV default, the DATA_W default and the mode-0 constant.
REQ-033 The half-period tick counter SHALL be a sub-module spi_clk_tick (inputs clk, rst_n, clear, enable; output tick).
REQ-034 The arbiter, FSM and shift registers SHALL reside in spi_master_arb.

Verification
REQ-035 Single transfer: req_i=01, wdata0=0xA5, slave drives 0x3C -> MOSI 10100101 MSB-first on rising edges, CS low 72 cycles, done_o=01, rdata_o=0x3C.
REQ-036 Contention: req_i=11 from reset -> requester 0 served first, then requester 1; CS high between the two transfers for at least 5 cycles.
REQ-037 Fairness: req_i held at 11 for 4 transfers -> grant order 0,1,0,1, and each done_o pulses exactly one cycle.
REQ-038 Abort: rst_n low at the 5th SCLK rising edge -> CS=1, SCLK=0 the same cycle, no done_o; a following req_i=10 completes normally.
REQ-039 Early drop: req_i=01 dropped after 2 cycles, wdata0 changed to 0xFF -> transmitted byte still the latched value, done_o=01.
REQ-040 Parameter corner: CLK_DIV=2, DATA_W=8 -> CS low 36 cycles, SCLK period 4 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and defaults for the arbitrated SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int c_CLK_DIV_DEFAULT = 4;
  localparam int c_DATA_W_DEFAULT  = 8;

  // {CPOL, CPHA}; mode 0 idles SCLK low and samples on the rising edge.
  localparam logic [1:0] c_SPI_MODE = 2'b00;
  localparam logic       c_CPOL     = c_SPI_MODE[1];

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_clk_tick.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_tick
// Description : Half-period tick generator, one pulse every CLK_DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] c_TERM = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == c_TERM) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  assign tick = enable && !clear && (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/spi_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_arb
// Description : Two-requester round-robin arbitrated SPI mode-0 master.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int CLK_DIV = c_CLK_DIV_DEFAULT,
  parameter int DATA_W  = c_DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS,
  input  logic              MISO,
  output logic [DATA_W-1:0] data_mosi,
  output logic [DATA_W-1:0] data_miso
);

  localparam int                HALF_W      = $clog2(2 * DATA_W);
  localparam int                IDX_W       = $clog2(DATA_W);
  localparam logic [HALF_W-1:0] c_HALF_LAST = HALF_W'(2 * DATA_W - 1);

  spi_state_t        r_state, w_state;
  logic [1:0]        r_gnt, w_gnt, r_done, w_done, w_pick;
  logic [DATA_W-1:0] r_rdata, w_rdata, r_data_mosi, w_data_mosi, r_data_miso, w_data_miso;
  logic              r_sclk, w_sclk, r_mosi, w_mosi, r_cs, w_cs, r_last, w_last;
  logic [HALF_W-1:0] r_half, w_half;
  logic [IDX_W-1:0]  r_bit_idx, w_bit_idx;
  logic              w_grant, w_tick;

  assign w_grant = (r_state == ST_IDLE) && (|req_i);

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_grant),
    .enable (r_state != ST_IDLE),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rdata     <= '0;
      r_data_mosi <= '0;
      r_data_miso <= '0;
      r_sclk      <= c_CPOL;
      r_mosi      <= 1'b0;
      r_cs        <= 1'b1;
      r_last      <= 1'b1;
      r_half      <= '0;
      r_bit_idx   <= '0;
    end else begin
      r_state     <= w_state;
      r_gnt       <= w_gnt;
      r_done      <= w_done;
      r_rdata     <= w_rdata;
      r_data_mosi <= w_data_mosi;
      r_data_miso <= w_data_miso;
      r_sclk      <= w_sclk;
      r_mosi      <= w_mosi;
      r_cs        <= w_cs;
      r_last      <= w_last;
      r_half      <= w_half;
      r_bit_idx   <= w_bit_idx;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_gnt       = r_gnt;
    w_done      = '0;
    w_rdata     = r_rdata;
    w_data_mosi = r_data_mosi;
    w_data_miso = r_data_miso;
    w_sclk      = r_sclk;
    w_mosi      = r_mosi;
    w_cs        = r_cs;
    w_last      = r_last;
    w_half      = r_half;
    w_bit_idx   = r_bit_idx;
    w_pick      = '0;
    case (r_state)
      ST_IDLE: begin
        if (|req_i) begin
          // r_last set means requester 1 was served last, so 0 wins a tie.
          w_pick      = (req_i == 2'b11) ? (r_last ? 2'b01 : 2'b10) : req_i;
          w_gnt       = w_pick;
          w_last      = w_pick[1];
          w_data_mosi = w_pick[1] ? wdata1_i : wdata0_i;
          w_mosi      = w_data_mosi[DATA_W-1];
          w_cs        = 1'b0;
          w_sclk      = c_CPOL;
          w_half      = '0;
          w_bit_idx   = IDX_W'(DATA_W - 1);
          w_state     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_tick) w_state = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_tick) begin
          w_sclk = ~r_sclk;
          if (!r_sclk) begin
            w_data_miso = {r_data_miso[DATA_W-2:0], MISO};
          end else if (r_half != c_HALF_LAST) begin
            w_bit_idx = r_bit_idx - 1'b1;
            w_mosi    = r_data_mosi[w_bit_idx];
          end
          if (r_half == c_HALF_LAST) w_state = ST_HOLD;
          else                       w_half  = r_half + 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_cs    = 1'b1;
          w_done  = r_gnt;
          w_rdata = r_data_miso;
          w_gnt   = '0;
          w_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_tick) w_state = ST_IDLE;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign gnt_o     = r_gnt;
  assign done_o    = r_done;
  assign rdata_o   = r_rdata;
  assign busy_o    = (r_state != ST_IDLE);
  assign SCLK      = r_sclk;
  assign MOSI      = r_mosi;
  assign CS        = r_cs;
  assign data_mosi = r_data_mosi;
  assign data_miso = r_data_miso;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_arb
// Description : Scoreboard bench for spi_master_arb with a mode-0 slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_arb;

  typedef struct {
    int         idx;
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  logic       clk, rst_n;
  logic [1:0] req;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, done;
  logic [7:0] rdata, dmosi, dmiso;
  logic       busy, sclk, mosi, cs, miso;

  logic [1:0] req2, gnt2, done2;
  logic [7:0] wd2, rdata2, dmosi2, dmiso2;
  logic       busy2, sclk2, mosi2, cs2;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  logic [7:0] slave_b0, slave_b1, tx_sh, rx_sh;
  logic       prev_sclk, prev_cs, have_window;
  logic [1:0] prev_done;
  int         rises, cs_cnt, gap_cnt, last_len;

  int   cyc, c2_cnt, c2_len, c2_period, c2_last_rise;
  logic p2_cs, p2_sclk;

  spi_master_arb u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .busy_o(busy),
    .SCLK(sclk), .MOSI(mosi), .CS(cs), .MISO(miso),
    .data_mosi(dmosi), .data_miso(dmiso)
  );

  // Second instance at the minimum divider, MISO looped back from MOSI.
  spi_master_arb #(.CLK_DIV(2), .DATA_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_i(req2), .wdata0_i(wd2), .wdata1_i(8'h00),
    .gnt_o(gnt2), .done_o(done2), .rdata_o(rdata2), .busy_o(busy2),
    .SCLK(sclk2), .MOSI(mosi2), .CS(cs2), .MISO(mosi2),
    .data_mosi(dmosi2), .data_miso(dmiso2)
  );

  assign miso = tx_sh[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Slave model, window measurement and scoreboard monitor in one process.
  always @(negedge clk) begin
    if (!rst_n) begin
      tx_sh = 8'h00; rx_sh = 8'h00; rises = 0; cs_cnt = 0; gap_cnt = 0;
      prev_sclk = 1'b0; prev_cs = 1'b1; prev_done = 2'b00; have_window = 1'b0;
    end else begin
      if (prev_cs && !cs) begin
        tx_sh  = gnt[1] ? slave_b1 : slave_b0;
        rises  = 0;
        cs_cnt = 0;
        if (have_window) begin
          n_tests++;
          if (gap_cnt < 5) begin
            n_fail++;
            $display("FAIL cs_gap: got %0d cycles required >= 5", gap_cnt);
          end
        end
        gap_cnt = 0;
      end
      if (!prev_sclk && sclk) begin
        rx_sh = {rx_sh[6:0], mosi};
        rises++;
      end
      if (prev_sclk && !sclk && !cs) tx_sh = {tx_sh[6:0], 1'b0};
      if (!cs) cs_cnt++;
      else     gap_cnt++;
      if (!prev_cs && cs) begin
        last_len    = cs_cnt;
        have_window = 1'b1;
      end
      if (prev_done != 2'b00) check("done_width", {30'd0, done}, 32'd0);
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {30'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_o",    {30'd0, done}, 32'd1 << e.idx);
          check("rdata_o",   {24'd0, rdata}, {24'd0, e.rx});
          check("mosi_byte", {24'd0, rx_sh}, {24'd0, e.tx});
          check("sclk_rises", rises, 8);
          check("cs_low_len", last_len, 72);
        end
      end
      prev_sclk = sclk;
      prev_cs   = cs;
      prev_done = done;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!cs2) c2_cnt++;
    if (p2_cs && !cs2) begin
      c2_cnt       = 1;
      c2_last_rise = -1;
    end
    if (!p2_cs && cs2) c2_len = c2_cnt;
    if (!p2_sclk && sclk2) begin
      if (c2_last_rise >= 0) c2_period = cyc - c2_last_rise;
      c2_last_rise = cyc;
    end
    p2_cs   = cs2;
    p2_sclk = sclk2;
  end

  task automatic wait_done(input int idx, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (done[idx]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no done_o[%0d] within 600 cycles", nm, idx);
    end
  endtask

  initial begin
    cyc = 0; c2_cnt = 0; c2_len = 0; c2_period = 0; c2_last_rise = -1;
    p2_cs = 1'b1; p2_sclk = 1'b0; last_len = 0;
    rst_n = 1'b0; req = 2'b00; wdata0 = 8'h00; wdata1 = 8'h00;
    slave_b0 = 8'h00; slave_b1 = 8'h00; req2 = 2'b00; wd2 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs_sclk_mosi", {29'd0, cs, sclk, mosi}, 32'b100);
    check("rst_gnt_done_busy", {27'd0, gnt, done, busy}, 32'd0);
    check("rst_data", {8'd0, rdata, dmosi, dmiso}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single transfer from requester 0.
    wdata0 = 8'hA5; slave_b0 = 8'h3C;
    sb.push_back('{0, 8'hA5, 8'h3C});
    req = 2'b01;
    @(posedge clk); #1;
    check("grant_latency", {28'd0, cs, gnt, mosi}, 32'b0011);
    check("latched_tx", {24'd0, dmosi}, 32'hA5);
    check("busy_after_grant", {31'd0, busy}, 32'd1);
    wait_done(0, "single");
    req = 2'b00;
    repeat (8) @(negedge clk);
    check("idle_after_single", {30'd0, busy, cs}, 32'b01);

    // Contention straight out of reset: 0 then 1.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wdata0 = 8'h11; wdata1 = 8'hC3; slave_b0 = 8'h81; slave_b1 = 8'h7E;
    sb.push_back('{0, 8'h11, 8'h81});
    sb.push_back('{1, 8'hC3, 8'h7E});
    req = 2'b11;
    wait_done(0, "contend0");
    req = 2'b10;
    wait_done(1, "contend1");
    req = 2'b00;
    repeat (8) @(negedge clk);

    // Fairness with both requests held for four transfers.
    wdata0 = 8'h0F; wdata1 = 8'hF0; slave_b0 = 8'h55; slave_b1 = 8'hAA;
    for (int k = 0; k < 4; k++) sb.push_back('{k % 2, (k % 2) ? 8'hF0 : 8'h0F, (k % 2) ? 8'hAA : 8'h55});
    req = 2'b11;
    for (int k = 0; k < 4; k++) wait_done(k % 2, "fair");
    req = 2'b00;
    repeat (8) @(negedge clk);

    // Abort with reset at the fifth SCLK rising edge.
    wdata0 = 8'h33; slave_b0 = 8'hCC;
    req = 2'b01;
    begin
      int   r = 0;
      logic ps = 1'b0;
      for (int i = 0; i < 400 && r < 5; i++) begin
        @(negedge clk);
        if (!ps && sclk) r++;
        ps = sclk;
      end
      check("abort_reached_5th_rise", r, 5);
    end
    rst_n = 1'b0;
    #1;
    check("abort_cs_sclk", {30'd0, cs, sclk}, 32'b10);
    check("abort_gnt_done_busy", {27'd0, gnt, done, busy}, 32'd0);
    check("abort_rdata", {24'd0, rdata}, 32'd0);
    req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    wdata1 = 8'h96; slave_b1 = 8'h69;
    sb.push_back('{1, 8'h96, 8'h69});
    req = 2'b10;
    wait_done(1, "after_abort");
    req = 2'b00;
    repeat (8) @(negedge clk);

    // Early request drop and write data change after grant.
    wdata0 = 8'h5A; slave_b0 = 8'hC6;
    sb.push_back('{0, 8'h5A, 8'hC6});
    req = 2'b01;
    repeat (2) @(negedge clk);
    req = 2'b00; wdata0 = 8'hFF;
    @(negedge clk);
    check("early_drop_latched", {24'd0, dmosi}, 32'h5A);
    wait_done(0, "early_drop");
    repeat (8) @(negedge clk);

    // Divider corner on the second instance.
    wd2 = 8'hB4;
    req2 = 2'b01;
    begin
      logic [1:0] d2 = 2'b00;
      for (int i = 0; i < 300 && d2 == 2'b00; i++) begin
        @(negedge clk);
        d2 = done2;
      end
      req2 = 2'b00;
      check("div2_done", {30'd0, d2}, 32'b01);
    end
    @(negedge clk);
    check("div2_cs_len", c2_len, 36);
    check("div2_sclk_period", c2_period, 4);
    check("div2_loopback", {24'd0, rdata2}, 32'hB4);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
